// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side and memory-side signals for mem_port_arbiter.
// The master modport is the arbiter; the slave modport is the pipeline plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      if_req;
    logic [ADDR_WIDTH-1:0]     if_addr;
    logic                      flush;
    logic                      if_done;
    logic [DATA_WIDTH-1:0]     if_rdata;
    logic                      me_req;
    logic                      me_we;
    logic [DATA_WIDTH/8-1:0]   me_wstrb;
    logic [ADDR_WIDTH-1:0]     me_addr;
    logic [DATA_WIDTH-1:0]     me_wdata;
    logic                      me_done;
    logic [DATA_WIDTH-1:0]     me_rdata;
    logic                      err;
    logic                      stall_if;
    logic                      stall_me;
    logic                      mem_req;
    logic                      mem_we;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_ready;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        input  if_req, if_addr, flush,
        input  me_req, me_we, me_wstrb, me_addr, me_wdata,
        input  mem_ready, mem_rdata,
        output if_done, if_rdata, me_done, me_rdata, err,
        output stall_if, stall_me,
        output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, flush,
        output me_req, me_we, me_wstrb, me_addr, me_wdata,
        output mem_ready, mem_rdata,
        input  if_done, if_rdata, me_done, me_rdata, err,
        input  stall_if, stall_me,
        input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (IF) and memory (ME) pipeline stages,
// with an IF starvation guard, flush discard of fetches and a transfer timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SCW        = $clog2(STARVE_MAX + 1);
    localparam int TCW        = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, IF_XFER, ME_XFER} state_t;

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    if_done_q, if_done_d;
    logic                    me_done_q, me_done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]   me_rdata_q, me_rdata_d;
    logic [SCW-1:0]          starve_q, starve_d;
    logic [TCW-1:0]          tout_q, tout_d;
    logic                    discard_q, discard_d;

    logic if_ok, me_ok, starved, grant_if, grant_me;
    logic timed_out, finish, drop_if;

    // A requester is ignored in the cycle its own done pulse is showing.
    assign if_ok     = bus.if_req & ~if_done_q & ~bus.flush;
    assign me_ok     = bus.me_req & ~me_done_q;
    assign starved   = (starve_q == SCW'(STARVE_MAX));
    assign grant_me  = (state_q == IDLE) & me_ok & ~(if_ok & starved);
    assign grant_if  = (state_q == IDLE) & if_ok & ~grant_me;
    assign timed_out = (state_q != IDLE) & ~bus.mem_ready & (tout_q == TCW'(TIMEOUT - 1));
    assign finish    = (state_q != IDLE) & (bus.mem_ready | timed_out);
    assign drop_if   = (state_q == IF_XFER) & (discard_q | bus.flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            me_done_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
            starve_q    <= '0;
            tout_q      <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            me_done_q   <= me_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
            starve_q    <= starve_d;
            tout_q      <= tout_d;
            discard_q   <= discard_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        me_done_d   = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        starve_d    = starve_q;
        tout_d      = tout_q;
        discard_d   = discard_q;

        case (state_q)
            IDLE: begin
                if (grant_me) begin
                    state_d     = ME_XFER;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.me_we;
                    mem_wstrb_d = bus.me_we ? bus.me_wstrb : '0;
                    mem_addr_d  = bus.me_addr;
                    mem_wdata_d = bus.me_wdata;
                    tout_d      = '0;
                end else if (grant_if) begin
                    state_d     = IF_XFER;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    tout_d      = '0;
                end
            end
            IF_XFER, ME_XFER: begin
                // A timeout completes like a normal transfer but returns zero data and flags err.
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (state_q == IF_XFER) begin
                        if (!drop_if) begin
                            if_done_d  = 1'b1;
                            err_d      = timed_out;
                            if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                        end
                    end else begin
                        me_done_d = 1'b1;
                        err_d     = timed_out;
                        if (!mem_we_q) begin
                            me_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                        end
                    end
                end else begin
                    tout_d = tout_q + TCW'(1);
                    if (state_q == IF_XFER && bus.flush) begin
                        discard_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Counts ME wins while IF is asking; any IF win or an idle IF clears it.
        if (!bus.if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_me && !starved) begin
            starve_d = starve_q + SCW'(1);
        end
    end

    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.me_done   = me_done_q;
    assign bus.me_rdata  = me_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req & ~if_done_q;
    assign bus.stall_me  = bus.me_req & ~me_done_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
